// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared constants and FSM state type for the bit-serial SPM core
package spm_pkg;

    localparam int SPM_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } spm_state_e;

    // Counter width needed to count the 2n product bits of an n-bit operation
    function automatic int spm_cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

    localparam int SPM_CNT_W = spm_cnt_width(SPM_N);

endpackage

// File: rtl/spm_serial_core_csa_cell.sv
// rtl/spm_serial_core_csa_cell.sv - registered full adder cell of the carry-save chain
module spm_csa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic sum
);

    logic sum_q, sum_d;
    logic carry_q, carry_d;

    // Add the partial-product bit and the neighbour's sum to the carry kept in this cell
    always_comb begin
        sum_d   = a ^ b ^ carry_q;
        carry_d = (a & b) | (a & carry_q) | (b & carry_q);
    end

    // Sum and carry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/spm_serial_core.sv
// rtl/spm_serial_core.sv - bit-serial serial/parallel multiplier, LSB-first product stream; SPM_SIGNED_EN selects signed operands
module spm_serial_core
    import spm_pkg::*;
#(
    parameter int N = SPM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         p_bit,
    output logic         p_valid,
    output logic         p_first,
    output logic         p_last,
    output logic         neg
);

    localparam int CNT_W = spm_cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N - 1);

    spm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     xm_q, xm_d;
    logic [2*N-1:0]   ysr_q, ysr_d;
    logic             neg_q, neg_d;

    logic [N-1:0]     x_mag;
    logic [N-1:0]     y_mag;
    logic             neg_calc;
    logic [N-1:0]     cell_a;
    logic [N-1:0]     cell_sum;
    logic             feed;

    // Operand magnitudes and product sign as seen at start acceptance
    always_comb begin
`ifdef SPM_SIGNED_EN
        x_mag    = x[N-1] ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;
        y_mag    = y[N-1] ? (~y + {{(N-1){1'b0}}, 1'b1}) : y;
        neg_calc = (x[N-1] ^ y[N-1]) & (|x) & (|y);
`else
        x_mag    = x;
        y_mag    = y;
        neg_calc = 1'b0;
`endif
    end

    // Next-state logic: accept, one load cycle, then 2N run cycles shifting y out LSB first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xm_d    = xm_q;
        ysr_d   = ysr_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    xm_d    = x_mag;
                    ysr_d   = {{N{1'b0}}, y_mag};
                    neg_d   = neg_calc;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                ysr_d   = ysr_q >> 1;
                state_d = RUN;
            end
            RUN: begin
                ysr_d = ysr_q >> 1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xm_q    <= '0;
            ysr_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xm_q    <= xm_d;
            ysr_q   <= ysr_d;
            neg_q   <= neg_d;
        end
    end

    // The edge leaving LOAD already consumes y bit 0, so bit 0 lands in cell 0 as RUN begins.
    // The chain drains to all-zero after every full run (the product fits in 2N bits),
    // so it needs no explicit clear; feeding zeros in IDLE keeps it there.
    assign feed = (state_q != IDLE);

    // Partial-product bits for each cell
    always_comb begin
        cell_a = xm_q & {N{ysr_q[0] & feed}};
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            if (gi == N - 1) begin : g_top
                spm_csa_cell u_cell (
                    .clk (clk),
                    .rst (rst),
                    .a   (cell_a[gi]),
                    .b   (1'b0),
                    .sum (cell_sum[gi])
                );
            end else begin : g_mid
                spm_csa_cell u_cell (
                    .clk (clk),
                    .rst (rst),
                    .a   (cell_a[gi]),
                    .b   (cell_sum[gi+1]),
                    .sum (cell_sum[gi])
                );
            end
        end
    endgenerate

    assign busy    = (state_q != IDLE);
    assign p_valid = (state_q == RUN);
    assign p_first = (state_q == RUN) && (cnt_q == '0);
    assign p_last  = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign p_bit   = cell_sum[0];
    assign neg     = neg_q;

endmodule

// File: tb/tb_spm_serial_core.sv
// tb/tb_spm_serial_core.sv - scoreboard bench for spm_serial_core (build with SPM_SIGNED_EN for the signed vectors)
module tb_spm_serial_core;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy, p_bit, p_valid, p_first, p_last, neg;

    spm_serial_core #(.N(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .p_bit   (p_bit),
        .p_valid (p_valid),
        .p_first (p_first),
        .p_last  (p_last),
        .neg     (neg)
    );

    typedef struct {
        logic [15:0] prod;
        logic        neg;
        int          first_cyc;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          k = 0;
    logic [15:0] acc;
    int          cur_first_cyc;
    logic        framing_bad;
    logic        neg_seen;
    logic        neg_unstable;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: assemble each 16-bit stream and compare against the scoreboard head
    always @(negedge clk) begin
        if (!rst && p_valid) begin
            if (k == 0) begin
                cur_first_cyc = cyc;
                framing_bad   = 1'b0;
                neg_seen      = neg;
                neg_unstable  = 1'b0;
                acc           = '0;
            end
            acc[k] = p_bit;
            if (p_first != (k == 0))  framing_bad = 1'b1;
            if (p_last  != (k == 15)) framing_bad = 1'b1;
            if (neg != neg_seen)      neg_unstable = 1'b1;
            if (k == 15) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_stream", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("product", int'(acc), int'(e.prod));
                    chk("neg", int'(neg_seen), int'(e.neg));
                    chk("neg_stable", int'(neg_unstable), 0);
                    chk("framing", int'(framing_bad), 0);
                    chk("first_latency", cur_first_cyc, e.first_cyc);
                end
                k = 0;
            end else begin
                k++;
            end
        end
    end

    always @(posedge rst) k = 0;

    // mode 0: plain op; 1: stray starts mid-run and on p_last; 2: reset at bit 7 (no result expected)
    task automatic do_op(input logic [7:0] xv, input logic [7:0] yv,
                         input logic [15:0] prod, input logic ng, input int mode);
        bit seen;
        @(negedge clk);
        x = xv;
        y = yv;
        start = 1'b1;
        if (mode != 2) begin
            exp_t e;
            e.prod = prod;
            e.neg = ng;
            e.first_cyc = cyc + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        if (mode == 1) begin
            repeat (4) @(negedge clk);
            x = 8'hFF;
            y = 8'hFF;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (p_last) seen = 1'b1;
                else @(negedge clk);
            end
            chk("p_last_seen", int'(seen), 1);
            x = 8'h81;
            y = 8'h7F;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("ignore_start_last_busy", int'(busy), 0);
            chk("ignore_start_last_valid", int'(p_valid), 0);
        end else if (mode == 2) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (p_valid) seen = 1'b1;
                else @(negedge clk);
            end
            chk("p_valid_seen", int'(seen), 1);
            repeat (7) @(negedge clk);
            #1 rst = 1'b1;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_p_bit", int'(p_bit), 0);
            chk("rst_p_valid", int'(p_valid), 0);
            chk("rst_p_first", int'(p_first), 0);
            chk("rst_p_last", int'(p_last), 0);
            chk("rst_neg", int'(neg), 0);
            @(negedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("post_rst_idle", int'(busy), 0);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (!busy) seen = 1'b1;
            else @(negedge clk);
        end
        chk("busy_drop", int'(seen), 1);
    endtask

    initial begin
        start = 1'b0;
        x = '0;
        y = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_outputs", int'({p_bit, p_valid, p_first, p_last, neg}), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);

`ifdef SPM_SIGNED_EN
        do_op(8'hFD, 8'h05, 16'h000F, 1'b1, 0);
        do_op(8'h80, 8'h80, 16'h4000, 1'b0, 0);
        do_op(8'h00, 8'hFB, 16'h0000, 1'b0, 0);
        do_op(8'h7F, 8'h81, 16'h3F01, 1'b1, 0);
        do_op(8'h03, 8'h05, 16'h000F, 1'b0, 0);
        do_op(8'hEE, 8'hCC, 16'h03A8, 1'b0, 1);
        do_op(8'hEE, 8'h34, 16'h03A8, 1'b1, 2);
        do_op(8'hEE, 8'h34, 16'h03A8, 1'b1, 0);
`else
        do_op(8'h03, 8'h05, 16'h000F, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 0);
        do_op(8'h00, 8'hA5, 16'h0000, 1'b0, 0);
        do_op(8'h80, 8'h02, 16'h0100, 1'b0, 0);
        do_op(8'h01, 8'h01, 16'h0001, 1'b0, 0);
        do_op(8'h12, 8'h34, 16'h03A8, 1'b0, 1);
        do_op(8'h12, 8'h34, 16'h03A8, 1'b0, 2);
        do_op(8'h12, 8'h34, 16'h03A8, 1'b0, 0);
`endif
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spm_serial_core.md
# spm_serial_core

Bit-serial serial/parallel multiplier core for the signed 8x8 SPM datapath. It accepts two N-bit operands on a start strobe and emits the 2N-bit product magnitude one bit per cycle, LSB first, with framing strobes. The stream feeds directly into the downstream serial two's-complement stage, which conditionally negates it. A sign flag is exported so that stage knows whether to negate.

## Interface
Parameters:
- N, 8, operand width; product stream is 2N bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while busy=0.
- x  input  N  parallel operand (multiplicand).
- y  input  N  operand consumed serially, LSB first.
- busy  output  1  high from the cycle after start is accepted through the last product bit.
- p_bit  output  1  current product bit.
- p_valid  output  1  p_bit is valid this cycle.
- p_first  output  1  marks product bit 0.
- p_last  output  1  marks product bit 2N-1.
- neg  output  1  product sign for downstream negation; stable while p_valid=1.

## Operation
- FSM states:
  - IDLE: busy=0; start=1 -> LOAD.
  - LOAD: one cycle; operands and sign are already latched; core cleared -> RUN.
  - RUN: exactly 2N cycles, counted by a ceil(log2(2N))-bit counter; after the cycle with count = 2N-1 -> IDLE.
- At start acceptance, latch the magnitude of x into the parallel register and the magnitude of y into a 2N-bit shift register, with the upper N bits zero.
- Core: N carry-save cells in a chain.
  - Each RUN cycle, cell i adds (xm[i] & y_serial) to its saved sum and carry.
  - The chain shifts toward LSB.
  - Cell 0 sum is the registered p_bit.
- Arithmetic: p_bit on the k-th valid cycle (k = 0..2N-1) equals bit k of xm*ym, unsigned. The result is exact; there is no overflow because xm and ym are at most 2^(N-1) when signed and at most 2^N-1 when unsigned.
- p_valid = 1 on all 2N RUN output cycles. p_first is high on k=0 only, p_last on k=2N-1 only.
- start while busy=1 is ignored, including in the p_last cycle. A back-to-back operation needs start in a cycle with busy=0.
- x and y are don't-care except in the start-acceptance cycle.

## Timing
- Reset values: busy=0, p_bit=0, p_valid=0, p_first=0, p_last=0, neg=0, FSM=IDLE, counter=0, all cell sum/carry=0.
- Let E0 be the edge that samples start=1.
  - busy rises after E0.
  - p_valid/p_first are high after E1.
  - p_last is high after E(2N).
  - busy and p_valid fall after E(2N+1).
- Latency: start to first bit = 2 cycles. Start to last bit = 2N+1 cycles. Minimum start-to-start interval = 2N+2 cycles.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). After deassertion the core is in IDLE. No partial stream resumes.
- neg is updated only at start acceptance and holds until the next acceptance.

## Configuration
- SPM_SIGNED_EN defined:
  - x and y are two's complement.
  - xm = |x| and ym = |y| are computed as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) fits).
  - neg = x[N-1] ^ y[N-1], except neg = 0 when either operand is zero.
- SPM_SIGNED_EN undefined:
  - x and y are unsigned.
  - xm = x, ym = y.
  - neg is tied to 0.

## Structure
- Shared package spm_pkg:
  - default N;
  - the FSM state enum (IDLE, LOAD, RUN);
  - the counter width constant derived from 2N.
- One sub-module, spm_csa_cell: a registered full adder with inputs a, b and clk/rst, holding its own sum and carry flops. It is instantiated N times.

## Test plan
- Unsigned, x=3, y=5 -> p_bit stream LSB first 1,1,1,1 then twelve 0s; p_first on bit 0, p_last on bit 15; neg=0.
- Unsigned, x=255, y=255 -> stream equals 0xFE01 LSB first.
- x=0, y=0xA5 -> sixteen 0s with correct p_valid/p_first/p_last framing.
- SPM_SIGNED_EN, x=-3 (0xFD), y=5:
  - stream equals 15;
  - neg=1.
- SPM_SIGNED_EN, x=-128, y=-128:
  - stream equals 0x4000;
  - neg=0.
- Control:
  - start pulsed mid-RUN and in the p_last cycle -> ignored; the stream is unaffected.
  - rst asserted at bit 7 -> all outputs 0 immediately.
  - A fresh start after deassertion yields a correct full stream.
